// File: rtl/bs_pkg.sv
// Shared definitions for the bit-serial modmul_bs datapath stages:
// capture-state encoding, default word width and a counter-width helper.
package bs_pkg;

    // Default word width of the serial datapath.
    localparam int BS_W = 16;

    // Capture state of a serial-to-parallel front end.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CAP  = 1'b1
    } cap_state_t;

    // Number of bits needed to hold the values 0..v-1 (minimum 1).
    function automatic int clog2(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bs_piso.sv
// Parallel-load, serial-out right shifter. A load presents bit 0 on o_q in
// the following cycle together with a one-cycle o_sync pulse; the select
// flag that came with the load is held on o_sel until the next load.
// Once all bits have left, o_q stays 0 (zero fill).
module bs_piso #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_sel,
    output logic         o_q,
    output logic         o_sync,
    output logic         o_sel
);

    logic [W-1:0] r_shift;
    logic         r_sync;
    logic         r_sel;

    // Load a new word or shift the current one towards bit 0, filling with zeros.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shift <= '0;
            r_sync  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_sync <= i_load;
            if (i_load) begin
                r_shift <= i_data;
                r_sel   <= i_sel;
            end else begin
                r_shift <= {1'b0, r_shift[W-1:1]};
            end
        end
    end

    assign o_q    = r_shift[0];
    assign o_sync = r_sync;
    assign o_sel  = r_sel;

endmodule

// File: rtl/bs_cond_select.sv
// Bit-serial conditional-subtract select stage. Captures one word of the
// original operand x and of the adder result s = x + (2^W - p), LSB first,
// and re-serializes r = (x >= p) ? s : x. The adder carry sampled on the
// word's MSB is exactly the (x >= p) decision.
// Optional feature: define BS_COND_SELECT_ABORT_CNT_EN to add the abort_cnt
// output, a saturating count of partial words discarded by a restart isync.
module bs_cond_select
    import bs_pkg::*;
#(
    parameter int W = BS_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x_in,
    input  logic       s_in,
    input  logic       isync,
    input  logic       icarry,
    output logic       q,
    output logic       osync,
    output logic       osel
`ifdef BS_COND_SELECT_ABORT_CNT_EN
    ,
    output logic [7:0] abort_cnt
`endif
);

    localparam int CW = clog2(W);
    localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

    cap_state_t    r_state;
    cap_state_t    w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [W-1:0]  r_xbuf;
    logic [W-1:0]  r_sbuf;

    logic          w_shift_en;
    logic          w_load;
    logic          w_abort;
    logic [W-1:0]  w_load_word;

    // Capture state and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next state: the isync cycle already carries bit 0, so the counter
    // leaves it holding 1 and r_cnt equals the index of the bit on the inputs.
    // On the MSB cycle a coinciding isync is ignored.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_shift_en   = 1'b0;
        w_load       = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            IDLE: begin
                if (isync) begin
                    w_state_next = CAP;
                    w_cnt_next   = CW'(1);
                    w_shift_en   = 1'b1;
                end
            end
            CAP: begin
                if (r_cnt == LAST_IDX) begin
                    w_load       = 1'b1;
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (isync) begin
                    w_abort    = 1'b1;
                    w_shift_en = 1'b1;
                    w_cnt_next = CW'(1);
                end else begin
                    w_shift_en = 1'b1;
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Capture buffers insert at the MSB end; after W-1 shifts bit 0 sits at
    // index 1, so the MSB taken straight from the inputs completes the word.
    // Contents outside a capture do not matter, hence no reset.
    always_ff @(posedge clk) begin
        if (w_shift_en) begin
            r_xbuf <= {x_in, r_xbuf[W-1:1]};
            r_sbuf <= {s_in, r_sbuf[W-1:1]};
        end
    end

    assign w_load_word = icarry ? {s_in, r_sbuf[W-1:1]} : {x_in, r_xbuf[W-1:1]};

    bs_piso #(
        .W (W)
    ) u_piso (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_data (w_load_word),
        .i_sel  (icarry),
        .o_q    (q),
        .o_sync (osync),
        .o_sel  (osel)
    );

`ifdef BS_COND_SELECT_ABORT_CNT_EN
    logic [7:0] r_abort_cnt;

    // Count discarded partial words, saturating at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_abort_cnt <= '0;
        end else if (w_abort && (r_abort_cnt != 8'hFF)) begin
            r_abort_cnt <= r_abort_cnt + 8'd1;
        end
    end

    assign abort_cnt = r_abort_cnt;
`endif

endmodule

// File: tb/tb_bs_cond_select.sv
// Directed bench for bs_cond_select with W=8 and p=3 (upstream adder adds
// 253). A collector assembles each output word from osync/q; the main
// sequence compares words, select flags and latency against hand values.
`timescale 1ns/1ps
module tb_bs_cond_select;

    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;
    logic x_in;
    logic s_in;
    logic isync;
    logic icarry;
    logic q;
    logic osync;
    logic osel;
`ifdef BS_COND_SELECT_ABORT_CNT_EN
    logic [7:0] abort_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int stray    = 0;

    int          exp_cyc[$];
    logic [7:0]  got_data[$];
    logic        got_sel[$];
    logic        got_selok[$];
    int          got_cyc[$];

    bs_cond_select #(
        .W (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .x_in   (x_in),
        .s_in   (s_in),
        .isync  (isync),
        .icarry (icarry),
        .q      (q),
        .osync  (osync),
        .osel   (osel)
`ifdef BS_COND_SELECT_ABORT_CNT_EN
        ,
        .abort_cnt (abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output collector: assembles W bits starting at each osync pulse.
    logic       col_active = 1'b0;
    int         col_idx    = 0;
    logic [7:0] col_word;
    logic       col_sel;
    logic       col_selok;
    int         col_cyc;

    always @(negedge clk) begin
        if (reset) begin
            col_active = 1'b0;
        end else begin
            if (osync) begin
                col_active = 1'b1;
                col_idx    = 0;
                col_word   = '0;
                col_sel    = osel;
                col_selok  = 1'b1;
                col_cyc    = cyc;
            end
            if (col_active) begin
                col_word[col_idx] = q;
                if (osel !== col_sel) col_selok = 1'b0;
                col_idx++;
                if (col_idx == W) begin
                    got_data.push_back(col_word);
                    got_sel.push_back(col_sel);
                    got_selok.push_back(col_selok);
                    got_cyc.push_back(col_cyc);
                    col_active = 1'b0;
                end
            end else if (q !== 1'b0) begin
                stray++;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic xb, input logic sb, input logic sy, input logic cy);
        x_in   = xb;
        s_in   = sb;
        isync  = sy;
        icarry = cy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) drive_bit(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [7:0] x, input logic [7:0] s, input logic c);
        exp_cyc.push_back(cyc + W);
        for (int i = 0; i < W; i++) begin
            drive_bit(x[i], s[i], (i == 0), (i == W - 1) ? c : 1'b0);
        end
    endtask

    task automatic send_partial(input logic [7:0] x, input logic [7:0] s, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            drive_bit(x[i], s[i], (i == 0), 1'b0);
        end
    endtask

    task automatic expect_word(input string tag, input logic [7:0] data, input logic sel);
        int n;
        int ec;
        n = 0;
        while (got_data.size() == 0 && n < 40) begin
            idle_bits(1);
            n++;
        end
        if (got_data.size() == 0) begin
            check_val({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            ec = (exp_cyc.size() != 0) ? exp_cyc.pop_front() : -1;
            check_val({tag, "_data"}, {24'd0, got_data.pop_front()}, {24'd0, data});
            check_val({tag, "_osel"}, {31'd0, got_sel.pop_front()}, {31'd0, sel});
            check_val({tag, "_osel_held"}, {31'd0, got_selok.pop_front()}, 32'd1);
            check_val({tag, "_latency"}, got_cyc.pop_front(), ec);
        end
    endtask

    initial begin
        reset  = 1'b1;
        x_in   = 1'b0;
        s_in   = 1'b0;
        isync  = 1'b0;
        icarry = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("rst_q", {31'd0, q}, 32'd0);
        check_val("rst_osync", {31'd0, osync}, 32'd0);
        check_val("rst_osel", {31'd0, osel}, 32'd0);
`ifdef BS_COND_SELECT_ABORT_CNT_EN
        check_val("rst_abort_cnt", {24'd0, abort_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_bits(2);

        // 1: x=5 >= 3 -> s = 0x02 selected
        send_word(8'd5, 8'h02, 1'b1);
        expect_word("t1_x5", 8'h02, 1'b1);

        // 2: x=2 < 3 -> x passes through
        send_word(8'd2, 8'hFF, 1'b0);
        expect_word("t2_x2", 8'h02, 1'b0);

        // 3: boundary x=p and x=0
        send_word(8'd3, 8'h00, 1'b1);
        expect_word("t3_x3", 8'h00, 1'b1);
        send_word(8'd0, 8'hFD, 1'b0);
        expect_word("t3_x0", 8'h00, 1'b0);

        // 4: three words back-to-back; latency checks imply contiguity
        send_word(8'd5, 8'h02, 1'b1);
        send_word(8'd2, 8'hFF, 1'b0);
        send_word(8'd4, 8'h01, 1'b1);
        expect_word("t4_w0", 8'h02, 1'b1);
        expect_word("t4_w1", 8'h02, 1'b0);
        expect_word("t4_w2", 8'h01, 1'b1);

        // 5: restart isync at bit 4 of x=7, then full x=6
        send_partial(8'd7, 8'h04, 4);
        send_word(8'd6, 8'h03, 1'b1);
        expect_word("t5_x6", 8'h03, 1'b1);
        idle_bits(12);
        check_val("t5_single_output", got_data.size(), 32'd0);
`ifdef BS_COND_SELECT_ABORT_CNT_EN
        check_val("t5_abort_cnt", {24'd0, abort_cnt}, 32'd1);
`endif

        // 6: word 0xC5 starts shifting out while the next capture is at bit 3 -> reset
        send_word(8'd200, 8'd197, 1'b1);
        send_partial(8'd5, 8'h02, 3);
        reset = 1'b1;
        drive_bit(1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_val("t6_rst_q", {31'd0, q}, 32'd0);
        check_val("t6_rst_osync", {31'd0, osync}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cyc.delete();
        idle_bits(12);
        check_val("t6_abandoned_none", got_data.size(), 32'd0);
`ifdef BS_COND_SELECT_ABORT_CNT_EN
        check_val("t6_abort_cnt_cleared", {24'd0, abort_cnt}, 32'd0);
`endif
        send_word(8'd5, 8'h02, 1'b1);
        expect_word("t6_after", 8'h02, 1'b1);
        idle_bits(4);

        check_val("zero_fill_stray_q", stray, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
